// File: rtl/pipeline_pkg.sv
// Shared state encoding and helpers for the pipeline skid stage.
package pipeline_pkg;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned OCC_W   = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_BUSY  = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  // Number of words held in a given state; illegal encodings report empty.
  function automatic logic [OCC_W-1:0] occ_of(input state_t s);
    case (s)
      ST_BUSY: occ_of = OCC_W'(1);
      ST_FULL: occ_of = OCC_W'(2);
      default: occ_of = OCC_W'(0);
    endcase
  endfunction
endpackage

// File: rtl/pipeline_slot.sv
// Load-enabled payload register with asynchronous clear to zero.
module pipeline_slot #(
  parameter int unsigned NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [NUM_BITS-1:0] d,
  output logic [NUM_BITS-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/pipeline_skid_stage.sv
// Receiving end of an inter-stage link: main slot drives the output, skid slot
// absorbs one word while the next stage stalls; flush squashes both.
module pipeline_skid_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [NUM_BITS-1:0] out_data,
  input  logic                out_ready,
  input  logic                flush,
  output logic [OCC_W-1:0]    occupancy
);
  state_t              state_q;
  state_t              state_d;
  logic                in_fire;
  logic                out_fire;
  logic                main_load;
  logic                main_sel_skid;
  logic                skid_load;
  logic [NUM_BITS-1:0] main_d;
  logic [NUM_BITS-1:0] skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign main_d   = main_sel_skid ? skid_q : in_data;

  // Next-state and slot load control.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          state_d       = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash wins over everything; slot contents are left untouched.
    if (flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // Handshake and occupancy outputs are flops decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != ST_FULL);
      out_valid <= (state_d == ST_BUSY) || (state_d == ST_FULL);
      occupancy <= occ_of(state_d);
    end
  end

  pipeline_slot #(.NUM_BITS(NUM_BITS)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  pipeline_slot #(.NUM_BITS(NUM_BITS)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );
endmodule
